// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: default operand width and
// controller state encoding.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl.
// master drives operands and consumes results; slave is the adder block.
interface serial_add_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );

endinterface

// File: rtl/fulladder.sv
// Single-bit full adder cell; the only arithmetic element in the datapath.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: accepts an operand pair, feeds one bit per
// cycle (LSB first) through a shared full adder, then holds the
// WIDTH+1-bit result until the consumer takes it.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_add_ctrl_if.slave   bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           state_nx;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry_q;
    logic [CW-1:0]    cnt;

    logic             fa_s;
    logic             fa_co;
    logic             last_bit;

    assign last_bit = (cnt == CW'(WIDTH - 1));

    fulladder u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: accept in IDLE, WIDTH bit-steps in RUN, hold in DONE.
    // NOTE: state_nx gets a default before the case so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nx = RUN;
            RUN:     if (last_bit)      state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, then shift one bit per RUN cycle.
    // NOTE: the shift registers are cleared by reset as well, so an aborted
    // operation leaves no residue and the block comes up in a known state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh    <= bus.a;
                        b_sh    <= bus.b;
                        carry_q <= bus.cin;
                        sum_sh  <= '0;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    sum_sh  <= {fa_s, sum_sh[WIDTH-1:1]};
                    carry_q <= fa_co;
                    a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
                    cnt     <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode straight from state; the result is masked outside DONE
    // so partial sums are never visible.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.sum       = (state == DONE) ? sum_sh : '0;
    assign bus.cout      = (state == DONE) & carry_q;

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  operand set offered.
REQ-005 SHALL have port: in_ready  output  1  block accepts operands this cycle.
REQ-006 SHALL have port: a  input  WIDTH  operand A.
REQ-007 SHALL have port: b  input  WIDTH  operand B.
REQ-008 SHALL have port: cin  input  1  carry-in.
REQ-009 SHALL have port: out_valid  output  1  result available.
REQ-010 SHALL have port: out_ready  input  1  consumer takes result.
REQ-011 SHALL have port: sum  output  WIDTH  result bits.
REQ-012 SHALL have port: cout  output  1  carry-out.
REQ-013 SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL sequence one shared 1-bit full adder, one operand bit per cycle, LSB first.
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 In IDLE: in_ready=1, out_valid=0; accept occurs on the edge where in_valid && in_ready; a, b and cin are then captured into shift and carry registers, the bit counter is cleared, and state goes to RUN.
REQ-017 In RUN: per cycle, full adder inputs are a_sh[0], b_sh[0] and carry_q; the sum bit shifts into the sum register MSB; carry_q is updated; a_sh and b_sh shift right; the counter increments.
REQ-018 RUN SHALL last exactly WIDTH cycles; on the edge where counter==WIDTH-1, state goes to DONE.
REQ-019 In DONE: out_valid=1, in_ready=0; sum and cout remain stable until the handshake.
REQ-020 On out_valid && out_ready, the FSM SHALL return to IDLE; no IDLE bypass; in_ready is never combinationally dependent on out_ready.
REQ-021 Latency: out_valid SHALL first be high in the cycle following the WIDTH-th rising edge after the accept edge.
REQ-022 Minimum accept-to-accept spacing SHALL be WIDTH+2 cycles.
REQ-023 Result SHALL satisfy {cout,sum} == a+b+cin (WIDTH+1-bit, no truncation); carry fully ripples, including all-ones + cin=1.
REQ-024 in_valid and operand changes while in_ready=0 SHALL be ignored and SHALL NOT corrupt an in-flight operation.
REQ-025 sum and cout SHALL read as 0 in IDLE and RUN; partial results are never visible.

Reset
REQ-026 rst_n low SHALL immediately (asynchronously) force: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, counter=0, carry_q=0, shift registers=0.
REQ-027 Reset asserted mid-RUN or mid-DONE SHALL abort the operation with no result emitted; the first accept after release SHALL compute correctly.
REQ-028 rst_n release SHALL be taken synchronously to clk; the first accept is possible on the first rising edge with rst_n high.

Structure
REQ-029 State encodings (IDLE/RUN/DONE) and the default WIDTH SHALL live in shared package serial_add_pkg.
REQ-030 The full-adder cell SHALL be exactly one instance of the existing fulladder module; no other arithmetic logic is permitted.
REQ-031 The counter SHALL be sized clog2(WIDTH)+1 bits.

Verification
REQ-032 WIDTH=8, a=0x5A, b=0x3C, cin=0, out_ready=1 -> sum=0x96, cout=0; out_valid high exactly one cycle, at the cycle after the 8th edge post-accept.
REQ-033 WIDTH=8, a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
REQ-034 Hold out_ready=0 for 5 cycles in DONE while presenting new in_valid=1, a=0x01 -> out_valid, sum and cout held, in_ready=0, new operands not taken; the old result is delivered on the first out_ready=1.
REQ-035 Drop rst_n in the 4th RUN cycle -> outputs reach reset values before the next edge, no out_valid; after release, 0x12+0x34+0 -> 0x46, cout=0.
REQ-036 in_valid held high with two queued operand sets, out_ready=1 -> both results correct; the second accept occurs exactly WIDTH+2 cycles after the first.
REQ-037 Random 1000 operations each at WIDTH=2 and WIDTH=8 with random out_ready stalls -> every {cout,sum} equals a+b+cin; busy matches state!=IDLE on every cycle.
